// File: rtl/traffic_interval_timer_if.sv
// Start/expiry signal bundle between the traffic light controller (master) and its interval timer (slave).
// The hold input exists only when TIMER_HOLD_EN is defined.
interface traffic_interval_timer_if #(
    parameter int CNT_W = 8
);
    logic             ST;
`ifdef TIMER_HOLD_EN
    logic             hold;
`endif
    logic             TS;
    logic             TL;
    logic             busy;
    logic [CNT_W-1:0] tick_cnt;

`ifdef TIMER_HOLD_EN
    modport master (output ST, output hold, input TS, input TL, input busy, input tick_cnt);
    modport slave  (input ST, input hold, output TS, output TL, output busy, output tick_cnt);
`else
    modport master (output ST, input TS, input TL, input busy, input tick_cnt);
    modport slave  (input ST, output TS, output TL, output busy, output tick_cnt);
`endif
endinterface

// File: rtl/traffic_interval_timer.sv
// Interval timer for the traffic light controller: prescaler -> tick counter -> level TS/TL flags.
// Optional pause input enabled by defining TIMER_HOLD_EN.
module traffic_interval_timer #(
    parameter int PRESCALE    = 10,
    parameter int SHORT_TICKS = 3,
    parameter int LONG_TICKS  = 8,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    traffic_interval_timer_if.slave  tif
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    generate
        if (PRESCALE < 1 || SHORT_TICKS < 1 || LONG_TICKS <= SHORT_TICKS ||
            LONG_TICKS >= (1 << CNT_W)) begin : g_paramCheck
            $fatal(1, "traffic_interval_timer: illegal PRESCALE/SHORT_TICKS/LONG_TICKS/CNT_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ts;
    logic             r_tl;
    logic             r_busy;

    state_t           w_stateNext;
    logic [PRE_W-1:0] w_preNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_tsNext;
    logic             w_tlNext;
    logic             w_busyNext;
    logic             w_hold;

`ifdef TIMER_HOLD_EN
    assign w_hold = tif.hold;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_ts    <= 1'b0;
            r_tl    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pre   <= w_preNext;
            r_cnt   <= w_cntNext;
            r_ts    <= w_tsNext;
            r_tl    <= w_tlNext;
            r_busy  <= w_busyNext;
        end
    end

    // Flags are derived from the next count so they land on the same edge as the tick.
    always_comb begin
        w_stateNext = r_state;
        w_preNext   = r_pre;
        w_cntNext   = r_cnt;
        w_tsNext    = r_ts;
        w_tlNext    = r_tl;
        w_busyNext  = r_busy;

        if (tif.ST) begin
            w_stateNext = RUN;
            w_preNext   = '0;
            w_cntNext   = '0;
            w_tsNext    = 1'b0;
            w_tlNext    = 1'b0;
            w_busyNext  = 1'b1;
        end else if (r_state == RUN && !w_hold) begin
            if (r_pre == PRE_W'(PRESCALE - 1)) begin
                w_preNext = '0;
                w_cntNext = r_cnt + 1'b1;
            end else begin
                w_preNext = r_pre + 1'b1;
            end
            w_tsNext = (w_cntNext >= CNT_W'(SHORT_TICKS));
            w_tlNext = (w_cntNext >= CNT_W'(LONG_TICKS));
            if (w_cntNext == CNT_W'(LONG_TICKS)) begin
                w_stateNext = DONE;
                w_busyNext  = 1'b0;
                w_preNext   = '0;
            end
        end
    end

    assign tif.TS       = r_ts;
    assign tif.TL       = r_tl;
    assign tif.busy     = r_busy;
    assign tif.tick_cnt = r_cnt;

endmodule

// File: doc/traffic_interval_timer.md
Name: traffic_interval_timer

Overview:
- Interval timer that drives the traffic light controller's timer inputs.
- Accepts the controller's start-timer request `ST`.
- Returns two level-held expiry flags: `TS` (short interval elapsed) and `TL` (long interval elapsed).
- Internally a clock prescaler feeds a tick counter, with a three-state run/done control FSM.

Parameters:
- PRESCALE, 10: clock cycles per timer tick; must be >= 1.
- SHORT_TICKS, 3: ticks until `TS` asserts; must be >= 1.
- LONG_TICKS, 8: ticks until `TL` asserts; must be > SHORT_TICKS and < 2**CNT_W.
- CNT_W, 8: width of the tick counter and of `tick_cnt`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ST  input  1  start/restart request from the controller, sampled on each clk edge.
- TS  output  1  short interval expired; level, held until next ST or reset.
- TL  output  1  long interval expired; level, held until next ST or reset.
- busy  output  1  high while counting (state RUN).
- tick_cnt  output  CNT_W  current tick count; saturates at LONG_TICKS.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, prescaler=0, tick_cnt=0, TS=0, TL=0, busy=0. All outputs are registered.
- States:
  - IDLE: after reset; counters frozen.
  - RUN: counting.
  - DONE: LONG_TICKS reached; counters frozen.
- ST=1 on any edge, in any state, forces RUN, prescaler=0, tick_cnt=0, TS=0, TL=0, busy=1. ST has priority over every other event on the same edge.
- RUN, ST=0:
  - If prescaler==PRESCALE-1, prescaler wraps to 0 and tick_cnt increments.
  - Otherwise prescaler increments.
  - PRESCALE=1 means tick_cnt increments every edge.
- TS_next=(tick_cnt_next >= SHORT_TICKS) and TL_next=(tick_cnt_next >= LONG_TICKS); both are registered with tick_cnt, with no extra cycle of lag.
- Latency: with the ST edge counted as edge 0, TS rises at edge SHORT_TICKS*PRESCALE and TL rises at edge LONG_TICKS*PRESCALE.
- When tick_cnt_next==LONG_TICKS: go to DONE on the same edge, busy=0, prescaler held at 0.
- DONE: TS=TL=1 and tick_cnt=LONG_TICKS are held indefinitely; there is no wrap-around.
- ST held high continuously: the block stays in RUN with counts at 0 and TS=TL=0. Counting starts on the first edge with ST=0.
- Reset mid-operation clears immediately, regardless of clk.
- Parameter violations are rejected at elaboration with a fatal message (generate-time check).

Optional Feature:
- Macro TIMER_HOLD_EN.
- When defined:
  - Adds input port `hold` (1 bit), placed after ST.
  - In RUN with hold=1 and ST=0, prescaler, tick_cnt, TS and TL all freeze; busy stays 1.
  - ST overrides hold.
  - hold has no effect in IDLE or DONE.
- When undefined: no `hold` port; counting is never paused.

Test Plan (PRESCALE=10, SHORT_TICKS=3, LONG_TICKS=8, 100 MHz clk):
1. Assert rst=0 for 3 cycles with ST=1 toggling, then release -> TS=TL=busy=0 and tick_cnt=0 throughout; state IDLE.
2. One-cycle ST pulse at edge 0 -> busy=1 after edge 0; tick_cnt=1 after edge 10; TS=1 after edge 30; TL=1 and busy=0 after edge 80; TS/TL still 1 at edge 500.
3. ST pulse, then a second ST pulse at edge 50 (TS=1, tick_cnt=5) -> TS=0 and tick_cnt=0 after edge 50; TS=1 again after edge 80; TL=1 after edge 130.
4. ST held high for 25 cycles, then dropped -> TS=0 and tick_cnt=0 for all 25 cycles; TS rises 30 edges after the last ST-high edge.
5. ST pulse, then rst=0 asynchronously mid-cycle at edge 45 -> TS, busy and tick_cnt clear before the next clk edge; after release the block remains IDLE until ST.
6. With TIMER_HOLD_EN: ST pulse, hold=1 for edges 15-34 -> tick_cnt frozen at 1; TS rises after edge 50 instead of 30; TL after edge 100.
